// File: rtl/add_round_key_stage.sv
// AES-128 AddRoundKey stage: XORs each beat with its round key, tracks the round sequence
// and buffers results in a 2-entry output FIFO (head presented on out_*).
module add_round_key_stage #(
   parameter int NR      = 10,
   parameter int STATE_W = 128
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [STATE_W-1:0] in_state,
   input  logic               in_first,
   output logic [3:0]         rk_idx,
   input  logic [STATE_W-1:0] rk_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [STATE_W-1:0] out_state,
   output logic [3:0]         out_round,
   output logic               out_last,
   output logic               sync_err,
   input  logic               clr_err
);

   localparam logic [3:0] LAST_RND = 4'(NR);

   typedef struct packed {
      logic [STATE_W-1:0] st;
      logic [3:0]         rnd;
      logic               last;
   } entry_t;

   logic [1:0] count_q, count_d;
   entry_t     e0_q, e0_d, e1_q, e1_d, new_e;
   logic [3:0] rnd_q, rnd_d, used;
   logic       err_q, err_d, push, pop, viol;

   assign in_ready  = (count_q != 2'd2);
   assign out_valid = (count_q != 2'd0);
   assign rk_idx    = used;
   assign out_state = e0_q.st;
   assign out_round = e0_q.rnd;
   assign out_last  = e0_q.last;
   assign sync_err  = err_q;

   always_comb begin
      used       = in_first ? 4'd0 : rnd_q;
      push       = in_valid && in_ready;
      pop        = out_valid && out_ready;
      viol       = push && (in_first ? (rnd_q != 4'd0) : (rnd_q == 4'd0));
      new_e.st   = in_state ^ rk_data;
      new_e.rnd  = used;
      new_e.last = (used == LAST_RND);

      rnd_d = rnd_q;
      if (push) rnd_d = new_e.last ? 4'd0 : used + 4'd1;

      // A violation in the same cycle as clr_err keeps the flag set
      err_d = viol ? 1'b1 : (clr_err ? 1'b0 : err_q);

      e0_d    = e0_q;
      e1_d    = e1_q;
      count_d = count_q;
      case ({push, pop})
         2'b10: begin
            if (count_q == 2'd0) e0_d = new_e;
            else                 e1_d = new_e;
            count_d = count_q + 2'd1;
         end
         2'b01: begin
            e0_d    = e1_q;
            count_d = count_q - 2'd1;
         end
         // Push with pop is only possible at count 1, so the new beat becomes the head
         2'b11:   e0_d = new_e;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= 2'd0;
         rnd_q   <= 4'd0;
         err_q   <= 1'b0;
         e0_q    <= '0;
         e1_q    <= '0;
      end else begin
         count_q <= count_d;
         rnd_q   <= rnd_d;
         err_q   <= err_d;
         e0_q    <= e0_d;
         e1_q    <= e1_d;
      end
   end

endmodule

// File: tb/tb_add_round_key_stage.sv
// Randomized bench for add_round_key_stage against a queue-based reference model.
module tb_add_round_key_stage;

   localparam int NR = 10;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid, in_first, out_ready, clr_err;
   logic         in_ready, out_valid, out_last, sync_err;
   logic [127:0] in_state, rk_data, out_state;
   logic [3:0]   rk_idx, out_round;
   logic [127:0] keys [0:15];

   always #5 clk = ~clk;

   // Round-key store: same-cycle lookup
   assign rk_data = keys[rk_idx];

   add_round_key_stage #(.NR(NR), .STATE_W(128)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_state(in_state), .in_first(in_first), .rk_idx(rk_idx), .rk_data(rk_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state),
      .out_round(out_round), .out_last(out_last), .sync_err(sync_err), .clr_err(clr_err)
   );

   typedef struct {
      logic [127:0] s;
      int           r;
      bit           l;
   } exp_t;

   exp_t mq[$];
   int   m_rnd;
   bit   m_err;
   int   n_cmp = 0;
   int   n_mis = 0;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic model_reset();
      mq.delete();
      m_rnd = 0;
      m_err = 1'b0;
   endtask

   // One clock cycle: drive at negedge, check settled outputs, update model at posedge
   task automatic step(input bit v, input logic [127:0] st, input bit first,
                       input bit ordy, input bit clr);
      int   used;
      bit   push, pop, viol;
      exp_t e;
      in_valid  = v;
      in_state  = st;
      in_first  = first;
      out_ready = ordy;
      clr_err   = clr;
      #1;
      used = first ? 0 : m_rnd;
      chk("rk_idx", 128'(rk_idx), 128'(used));
      chk("in_ready", 128'(in_ready), 128'(mq.size() != 2));
      chk("out_valid", 128'(out_valid), 128'(mq.size() != 0));
      chk("sync_err", 128'(sync_err), 128'(m_err));
      if (mq.size() != 0) begin
         chk("out_state", out_state, mq[0].s);
         chk("out_round", 128'(out_round), 128'(mq[0].r));
         chk("out_last", 128'(out_last), 128'(mq[0].l));
      end
      push = v && (mq.size() != 2);
      pop  = ordy && (mq.size() != 0);
      viol = push && (first ? (m_rnd != 0) : (m_rnd == 0));
      @(posedge clk);
      if (pop) void'(mq.pop_front());
      if (push) begin
         e.s = st ^ keys[used];
         e.r = used;
         e.l = (used == NR);
         mq.push_back(e);
         m_rnd = (used == NR) ? 0 : used + 1;
      end
      if (viol) m_err = 1'b1;
      else if (clr) m_err = 1'b0;
      @(negedge clk);
   endtask

   task automatic idle(input bit ordy);
      step(1'b0, '0, 1'b0, ordy, 1'b0);
   endtask

   initial begin
      bit first;
      keys[0] = 128'h000102030405060708090a0b0c0d0e0f;
      for (int i = 1; i < 16; i++) keys[i] = rnd128();
      rst_n = 1'b0; in_valid = 1'b0; in_first = 1'b0; out_ready = 1'b0;
      clr_err = 1'b0; in_state = '0;
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rst_out_valid", 128'(out_valid), 128'(0));
      chk("rst_in_ready", 128'(in_ready), 128'(1));
      chk("rst_sync_err", 128'(sync_err), 128'(0));
      chk("rst_out_state", out_state, 128'(0));
      chk("rst_out_round", 128'(out_round), 128'(0));
      chk("rst_out_last", 128'(out_last), 128'(0));
      chk("rst_rk_idx", 128'(rk_idx), 128'(0));
      @(negedge clk);

      // FIPS-197 round 0 vector
      step(1'b1, 128'h00112233445566778899aabbccddeeff, 1'b1, 1'b0, 1'b0);
      chk("fips_out_state", out_state, 128'h00102030405060708090a0b0c0d0e0f0);
      chk("fips_out_round", 128'(out_round), 128'(0));
      chk("fips_out_last", 128'(out_last), 128'(0));
      idle(1'b1);

      // Remaining rounds of that block, then a full back-to-back block
      for (int r = 1; r <= NR; r++) step(1'b1, rnd128(), 1'b0, 1'b1, 1'b0);
      for (int r = 0; r <= NR; r++) step(1'b1, rnd128(), r == 0, 1'b1, 1'b0);
      repeat (2) idle(1'b1);

      // Backpressure: three offered beats with the sink stalled, then drain
      for (int i = 0; i < 3; i++) step(1'b1, rnd128(), m_rnd == 0, 1'b0, 1'b0);
      chk("bp_in_ready_low", 128'(in_ready), 128'(0));
      step(1'b1, rnd128(), m_rnd == 0, 1'b1, 1'b0);
      repeat (4) idle(1'b1);

      // Sync error: early restart at round 5, then clr_err racing a violation, then clear
      while (m_rnd != 5) step(1'b1, rnd128(), m_rnd == 0, 1'b1, 1'b0);
      step(1'b1, rnd128(), 1'b1, 1'b1, 1'b0);
      chk("early_first_err", 128'(sync_err), 128'(1));
      chk("early_first_round", 128'(out_round), 128'(0));
      step(1'b1, rnd128(), 1'b1, 1'b1, 1'b1);
      chk("clr_vs_set", 128'(sync_err), 128'(1));
      step(1'b0, '0, 1'b0, 1'b1, 1'b1);
      chk("clr_alone", 128'(sync_err), 128'(0));
      repeat (2) idle(1'b1);

      // Unflagged start after reset
      rst_n = 1'b0;
      #1;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      step(1'b1, rnd128(), 1'b0, 1'b0, 1'b0);
      chk("unflagged_err", 128'(sync_err), 128'(1));
      chk("unflagged_round", 128'(out_round), 128'(0));

      // Reset mid-stream with a full FIFO and sync_err set
      step(1'b1, rnd128(), 1'b0, 1'b0, 1'b0);
      chk("full_before_rst", 128'(in_ready), 128'(0));
      #2;
      rst_n    = 1'b0;
      in_first = 1'b0;
      #1;
      chk("midrst_out_valid", 128'(out_valid), 128'(0));
      chk("midrst_in_ready", 128'(in_ready), 128'(1));
      chk("midrst_sync_err", 128'(sync_err), 128'(0));
      chk("midrst_rnd", 128'(rk_idx), 128'(0));
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;

      // Random traffic
      for (int c = 0; c < 400; c++) begin
         first = (m_rnd == 0);
         if ($urandom_range(0, 19) == 0) first = !first;
         step($urandom_range(0, 3) != 0, rnd128(), first,
              $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
      end
      repeat (3) idle(1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
